// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, size encodings and request legality check for lsu_rmw
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Illegal size encodings are folded into the same error as misalignment.
  function automatic logic req_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return lane[0];
      SZ_W:    return lane != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// rtl/lsu_lane.sv - little-endian lane extract/extend for loads and lane merge for sub-word stores
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte   = i_word[{i_addr, 3'b000} +: 8];
    w_half   = i_addr[1] ? i_word[31:16] : i_word[15:0];
    o_load   = i_word;
    o_merged = i_word;
    case (i_size)
      SZ_B: begin
        o_load = {{24{~i_unsigned & w_byte[7]}}, w_byte};
        o_merged[{i_addr, 3'b000} +: 8] = i_wdata[7:0];
      end
      SZ_H: begin
        o_load = {{16{~i_unsigned & w_half[15]}}, w_half};
        if (i_addr[1]) o_merged[31:16] = i_wdata[15:0];
        else           o_merged[15:0]  = i_wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_rmw.sv
// rtl/lsu_rmw.sv - load/store unit with read-modify-write for sub-word stores to a word-only memory
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t            r_state;
  state_t            w_next;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [1:0]        r_lane;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [31:0]       r_merged;
  logic [AWIDTH-3:0] r_mem_hi;
  logic              w_we;
  logic              w_bad;
  logic [31:0]       w_load;
  logic [31:0]       w_merged;

  lsu_lane u_lane (
    .i_word     (mem_rdata),
    .i_addr     (r_lane),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .i_wdata    (r_wdata),
    .o_load     (w_load),
    .o_merged   (w_merged)
  );

  assign w_bad      = req_misaligned(req_size, req_addr[1:0]);
  assign mem_addr   = {r_mem_hi, 2'b00};
  assign mem_we     = w_we & ~rst;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    w_we       = 1'b0;
    mem_wdata  = 32'h0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = w_bad ? RESP : EXEC;
      end
      EXEC: begin
        if (!r_we) begin
          w_next = RESP;
        end else if (r_size == SZ_W) begin
          w_we      = 1'b1;
          mem_wdata = r_wdata;
          w_next    = RESP;
        end else begin
          w_next = WRITE;
        end
      end
      WRITE: begin
        w_we      = 1'b1;
        mem_wdata = r_merged;
        w_next    = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // mem_addr only moves for legal requests so it holds its last value otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_size   <= SZ_B;
      r_uns    <= 1'b0;
      r_lane   <= 2'b00;
      r_wdata  <= 32'h0;
      r_rdata  <= 32'h0;
      r_err    <= 1'b0;
      r_merged <= 32'h0;
      r_mem_hi <= '0;
    end else begin
      if (r_state == IDLE && req_valid) begin
        r_we    <= req_we;
        r_size  <= req_size;
        r_uns   <= req_unsigned;
        r_lane  <= req_addr[1:0];
        r_wdata <= req_wdata;
        r_rdata <= 32'h0;
        r_err   <= w_bad;
        if (!w_bad) r_mem_hi <= req_addr[AWIDTH-1:2];
      end
      if (r_state == EXEC) begin
        if (!r_we) r_rdata <= w_load;
        r_merged <= w_merged;
      end
    end
  end

endmodule

// File: tb/tb_lsu_rmw.sv
// tb/tb_lsu_rmw.sv - scoreboard bench for lsu_rmw against a word-addressed memory model
module tb_lsu_rmw;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  logic [31:0] mem [0:15];
  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;

  logic [31:0] rd;
  logic        er, pv;
  int          lat, wc, aw;
  logic [3:0]  wm;
  exp_t        e;

  lsu_rmw #(.AWIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[5:2]];

  always @(posedge clk) if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] o_rd, output logic o_er, output int o_lat,
                        output int o_wc, output logic [3:0] o_wm, output int o_aw,
                        output logic o_pv);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    o_aw = 0;
    while (!req_ready && o_aw < 20) begin
      @(negedge clk);
      o_aw++;
    end
    if (!req_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: req_ready=%b after %0d cycles, want 1", req_ready, o_aw);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    o_lat = 1; o_wc = 0; o_wm = 4'b0;
    while (!resp_valid && o_lat < 20) begin
      if (mem_we) begin
        o_wc++;
        if (o_lat < 4) o_wm[o_lat] = 1'b1;
      end
      @(negedge clk);
      o_lat++;
    end
    if (!resp_valid) begin
      n_checks++; n_fail++;
      $display("FAIL resp_timeout: resp_valid=%b after %0d cycles, want 1", resp_valid, o_lat);
    end
    o_rd = resp_rdata;
    o_er = resp_err;
    @(negedge clk);
    o_pv = resp_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we_in_rst: got %b want 0", mem_we); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_resp_rdata: got %h want 0", resp_rdata); end
    n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
  endtask

  task automatic test_word();
    sb.push_back('{rdata: 32'h0, err: 1'b0, lat: 2});
    do_req(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF, rd, er, lat, wc, wm, aw, pv);
    e = sb.pop_front();
    n_checks++; if (rd !== e.rdata) begin n_fail++; $display("FAIL wstore_rdata: got %h want %h", rd, e.rdata); end
    n_checks++; if (er !== e.err) begin n_fail++; $display("FAIL wstore_err: got %b want %b", er, e.err); end
    n_checks++; if (lat != e.lat) begin n_fail++; $display("FAIL wstore_latency: got %0d want %0d", lat, e.lat); end
    n_checks++; if (wm !== 4'b0010 || wc != 1) begin n_fail++; $display("FAIL wstore_we_cycles: got mask %b count %0d want 0010 count 1", wm, wc); end
    n_checks++; if (pv !== 1'b0) begin n_fail++; $display("FAIL wstore_resp_one_cycle: got %b want 0", pv); end
    n_checks++; if (mem[2] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wstore_mem: got %h want deadbeef", mem[2]); end
    sb.push_back('{rdata: 32'hDEADBEEF, err: 1'b0, lat: 2});
    do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, rd, er, lat, wc, wm, aw, pv);
    e = sb.pop_front();
    n_checks++; if (rd !== e.rdata) begin n_fail++; $display("FAIL wload_rdata: got %h want %h", rd, e.rdata); end
    n_checks++; if (lat != e.lat || wc != 0) begin n_fail++; $display("FAIL wload_lat_we: got lat %0d we %0d want %0d 0", lat, wc, e.lat); end
  endtask

  task automatic test_subword_load();
    logic [1:0]  sz [3] = '{2'd0, 2'd0, 2'd1};
    logic        un [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] ad [3] = '{32'h9, 32'h9, 32'hA};
    logic [31:0] ex [3] = '{32'hFFFFFFBE, 32'h000000BE, 32'hFFFFDEAD};
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{rdata: ex[i], err: 1'b0, lat: 2});
      do_req(1'b0, sz[i], un[i], ad[i], 32'h0, rd, er, lat, wc, wm, aw, pv);
      e = sb.pop_front();
      n_checks++;
      if (rd !== e.rdata || er !== e.err || lat != e.lat) begin
        n_fail++;
        $display("FAIL subload_%0d: got rdata %h err %b lat %0d want %h %b %0d", i, rd, er, lat, e.rdata, e.err, e.lat);
      end
    end
  endtask

  task automatic test_subword_store();
    sb.push_back('{rdata: 32'h0, err: 1'b0, lat: 3});
    do_req(1'b1, 2'd1, 1'b0, 32'hA, 32'h00001234, rd, er, lat, wc, wm, aw, pv);
    e = sb.pop_front();
    n_checks++; if (lat != e.lat || er !== e.err || rd !== e.rdata) begin n_fail++; $display("FAIL hstore_resp: got lat %0d err %b rdata %h want %0d %b %h", lat, er, rd, e.lat, e.err, e.rdata); end
    n_checks++; if (wm !== 4'b0100 || wc != 1) begin n_fail++; $display("FAIL hstore_we_write_only: got mask %b count %0d want 0100 count 1", wm, wc); end
    n_checks++; if (mem[2] !== 32'h1234BEEF) begin n_fail++; $display("FAIL hstore_mem: got %h want 1234beef", mem[2]); end
    sb.push_back('{rdata: 32'h0, err: 1'b0, lat: 3});
    do_req(1'b1, 2'd0, 1'b0, 32'h8, 32'hABCDEF77, rd, er, lat, wc, wm, aw, pv);
    e = sb.pop_front();
    n_checks++; if (lat != e.lat || wm !== 4'b0100) begin n_fail++; $display("FAIL bstore_timing: got lat %0d mask %b want %0d 0100", lat, wm, e.lat); end
    n_checks++; if (mem[2] !== 32'h1234BE77) begin n_fail++; $display("FAIL bstore_mem: got %h want 1234be77", mem[2]); end
  endtask

  task automatic test_errors();
    logic        we [3] = '{1'b0, 1'b1, 1'b1};
    logic [1:0]  sz [3] = '{2'd1, 2'd2, 2'd3};
    logic [31:0] ad [3] = '{32'h9, 32'h6, 32'h8};
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{rdata: 32'h0, err: 1'b1, lat: 1});
      do_req(we[i], sz[i], 1'b0, ad[i], 32'hFFFFFFFF, rd, er, lat, wc, wm, aw, pv);
      e = sb.pop_front();
      n_checks++;
      if (rd !== e.rdata || er !== e.err || lat != e.lat || wc != 0) begin
        n_fail++;
        $display("FAIL error_%0d: got rdata %h err %b lat %0d we %0d want %h %b %0d 0", i, rd, er, lat, wc, e.rdata, e.err, e.lat);
      end
    end
    n_checks++; if (mem[1] !== 32'h0 || mem[2] !== 32'h1234BE77) begin n_fail++; $display("FAIL error_mem_untouched: got %h %h want 0 1234be77", mem[1], mem[2]); end
  endtask

  task automatic test_backpressure();
    int   tmo;
    logic bad;
    sb.push_back('{rdata: 32'h1234BE77, err: 1'b0, lat: 2});
    resp_ready = 1'b0;
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h8; req_wdata = 32'h0;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    tmo = 0;
    while (!resp_valid && tmo < 20) begin @(negedge clk); tmo++; end
    e = sb.pop_front();
    req_we = 1'b0; req_size = 2'd2; req_addr = 32'h0; req_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || req_ready !== 1'b0) bad = 1'b1;
      if (i < 2) @(negedge clk);
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL backpressure_hold: got valid %b rdata %h ready %b want 1 %h 0", resp_valid, resp_rdata, req_ready, e.rdata);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sb.push_back('{rdata: 32'h0, err: 1'b0, lat: 2});
    do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, rd, er, lat, wc, wm, aw, pv);
    e = sb.pop_front();
    n_checks++; if (aw != 0) begin n_fail++; $display("FAIL backpressure_accept_wait: got %0d want 0", aw); end
    n_checks++; if (rd !== e.rdata || lat != e.lat) begin n_fail++; $display("FAIL backpressure_next: got rdata %h lat %0d want %h %0d", rd, lat, e.rdata, e.lat); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h4; req_wdata = 32'h55;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL rstmid_write_cycle: got mem_we %b want 1", mem_we); end
    rst = 1'b1;
    #1;
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_we_gated: got %b want 0", mem_we); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_req_ready: got %b want 1", req_ready); end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_resp: got resp seen %b want 0", seen); end
    n_checks++; if (mem[1] !== 32'h0) begin n_fail++; $display("FAIL rstmid_mem: got %h want 0", mem[1]); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    test_reset();
    test_word();
    test_subword_load();
    test_subword_store();
    test_errors();
    test_backpressure();
    test_reset_mid();
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_rmw.md
# lsu_rmw

Load/store unit that sits between the pipeline's MEM stage and the word-addressed data memory and acts as the initiating side of that memory's interface. It accepts byte, halfword and word loads and stores through a valid/ready request channel and returns results through a valid/ready response channel. Sub-word loads are served by extracting and extending a lane of the read word. Sub-word stores are served by a two-cycle read-modify-write, because the memory writes whole words only.

## Interface
- AWIDTH, 32, byte-address width; data width is fixed at 32
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  in  1  loads only: zero-extend instead of sign-extend
- req_addr  in  AWIDTH  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes the response
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  misaligned or illegal-size request
- mem_addr  out  AWIDTH  byte address to memory, bits [1:0] always 0
- mem_we  out  1  memory write enable
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, combinational from mem_addr

## Operation
- States: IDLE, EXEC, WRITE, RESP.
- **IDLE**
  - req_ready = 1.
  - When req_valid && req_ready, latch we, size, unsigned, addr and wdata.
  - Legal request → EXEC. Error → RESP with resp_err = 1.
- **Errors**
  - size = 3.
  - size = 1 with addr[0] = 1.
  - size = 2 with addr[1:0] != 0.
  - An error request never drives mem_we.
- **EXEC**: mem_addr = {addr[AWIDTH-1:2], 2'b00}. Then by request type:
  - Load: select the lane from mem_rdata (little-endian; byte lane = addr[1:0], half lane = addr[1]). Sign- or zero-extend into the response register → RESP.
  - Word store: mem_we = 1, mem_wdata = wdata → RESP.
  - Sub-word store: merge the low bits of wdata into the addressed lane of mem_rdata, keeping the other bytes. Register the merged word → WRITE.
- **WRITE**: mem_we = 1, mem_wdata = merged word, mem_addr as in EXEC → RESP.
- **RESP**
  - resp_valid = 1; resp_rdata and resp_err are stable while resp_valid is high.
  - On resp_ready → IDLE; there is no same-cycle re-accept.
- req_ready = 0 in every state except IDLE, so at most one request is in flight.
- Outside EXEC and WRITE: mem_we = 0, mem_wdata = 0, mem_addr holds its last value.

## Timing
- Reset values: state = IDLE, req_ready = 1 from the first cycle after reset, resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_we = 0.
- Latency from the accept edge to the first resp_valid cycle:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- The memory write takes effect on the posedge that ends the EXEC or WRITE cycle.
- mem_we is gated by !rst, so reset in EXEC or WRITE writes nothing, and the aborted request produces no response.
- If resp_ready is held high, the response occupies exactly one cycle. Back-to-back requests are therefore spaced at least 3 cycles apart (loads and word stores) or 4 cycles apart (sub-word stores).
- req_* inputs are sampled only on the accept edge; changes after that are ignored.
- With resp_ready low, the unit holds RESP indefinitely with outputs unchanged.

## Structure
- Package lsu_pkg holds:
  - the state enum (IDLE, EXEC, WRITE, RESP);
  - the size encodings SZ_B = 0, SZ_H = 1, SZ_W = 2;
  - a misalignment-check function shared with the decoder.
- Sub-module lsu_lane is combinational. Inputs: word, addr[1:0], size, unsigned, wdata. Outputs: the extended load value and the merged store word. The FSM in lsu_rmw instantiates it once.

## Test plan
All cases start with memory zeroed.
- Word store of 0xDEADBEEF at 0x8: mem_we high for exactly 1 cycle, resp_valid 2 cycles after accept, resp_err = 0. A following word load at 0x8 returns 0xDEADBEEF.
- Byte loads at 0x9 after the above: signed returns 0xFFFFFFBE, unsigned returns 0x000000BE. Half load signed at 0xA returns 0xFFFFDEAD.
- Half store of 0x00001234 at 0xA: one EXEC read, then mem_we in WRITE only. The word at 0x8 becomes 0x1234BEEF. Byte store 0x77 at 0x8 then gives 0x1234BE77.
- Misaligned and illegal requests (half at 0x9, word at 0x6, size = 3): resp_err = 1 one cycle after accept, resp_rdata = 0, mem_we never asserted.
- Backpressure: hold resp_ready low for 3 cycles on a load. resp_valid and resp_rdata stay stable, req_ready = 0 throughout, and a req_valid presented meanwhile is not accepted until the cycle after IDLE is re-entered.
- Reset mid-operation: assert rst in the WRITE cycle of a byte store to 0x4. Memory at 0x4 is unchanged, no response is produced, and req_ready = 1 the cycle after reset deasserts.
